decode_stage: RTL and testbench

- Parametrised, handshaked successor of the single-register RV32I decode stage. Sits between fetch and register-read/execute.
- Accepts {instr, pc} over valid/ready. Produces registered decode fields: opcode, funct3, alt bit, register addresses, sign-extended immediate, write-enable and an illegal flag.
- A two-entry skid buffer decouples fetch from execute back-pressure without a combinational ready path. A synchronous flush squashes buffered instructions on redirect.

---
 rtl/rv_pkg.sv | 69 ++++++
 rtl/decode_logic.sv | 130 +++++++++++++
 rtl/decode_stage.sv | 140 ++++++++++++++
 tb/tb_decode_stage.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv_pkg.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : rv_pkg
// Brief    : Shared RV32I decode definitions: opcodes, immediate formats and
//            the decoded-entry record carried through the decode buffer.
// Revision : 1.0
// ============================================================================
package rv_pkg;

    // Entries are sized for the widest supported datapath; users slice down.
    localparam int c_XLEN_MAX = 64;
    localparam int c_RAW_AW   = 5;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_ALUI   = 7'b0010011;
    localparam logic [6:0] OP_ALU    = 7'b0110011;

    localparam logic [6:0] c_F7_BASE = 7'b0000000;
    localparam logic [6:0] c_F7_ALT  = 7'b0100000;
    localparam logic [6:0] c_F7_MEXT = 7'b0000001;

    typedef enum logic [2:0] {
        IMM_NONE = 3'd0,
        IMM_I    = 3'd1,
        IMM_S    = 3'd2,
        IMM_B    = 3'd3,
        IMM_U    = 3'd4,
        IMM_J    = 3'd5
    } imm_fmt_e;

    typedef struct packed {
        logic [c_XLEN_MAX-1:0] pc;
        logic [6:0]            opcode;
        logic [2:0]            funct3;
        logic                  alt;
        logic [c_RAW_AW-1:0]   rs1;
        logic [c_RAW_AW-1:0]   rs2;
        logic [c_RAW_AW-1:0]   rd;
        logic                  rs1_used;
        logic                  rs2_used;
        logic [c_XLEN_MAX-1:0] imm;
        logic                  we;
        logic                  illegal;
        logic                  mext;
    } decode_entry_t;

    function automatic imm_fmt_e imm_fmt_of(input logic [6:0] op);
        imm_fmt_e fmt;
        case (op)
            OP_LUI, OP_AUIPC:           fmt = IMM_U;
            OP_JAL:                     fmt = IMM_J;
            OP_JALR, OP_LOAD, OP_ALUI:  fmt = IMM_I;
            OP_BRANCH:                  fmt = IMM_B;
            OP_STORE:                   fmt = IMM_S;
            default:                    fmt = IMM_NONE;
        endcase
        return fmt;
    endfunction

endpackage

`default_nettype wire

// File: rtl/decode_logic.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : decode_logic
// Brief    : Combinational RV32I field decode (instr/pc -> decode_entry_t).
//            Define DECODE_MEXT_EN to accept RV32M register-register ops.
// Revision : 1.0
// ============================================================================
module decode_logic
    import rv_pkg::*;
(
    input  logic [31:0]           i_instr,
    input  logic [c_XLEN_MAX-1:0] i_pc,
    output decode_entry_t         o_entry
);

    logic [6:0]            w_op;
    logic [2:0]            w_f3;
    logic [6:0]            w_f7;
    logic                  w_sign;
    logic [c_XLEN_MAX-1:0] w_imm_i;
    logic [c_XLEN_MAX-1:0] w_imm_s;
    logic [c_XLEN_MAX-1:0] w_imm_b;
    logic [c_XLEN_MAX-1:0] w_imm_u;
    logic [c_XLEN_MAX-1:0] w_imm_j;
    logic [c_XLEN_MAX-1:0] w_imm;
    logic                  w_known;
    logic                  w_bad;
    logic                  w_wr;
    logic                  w_alt;
    logic                  w_rs1u;
    logic                  w_rs2u;
    logic                  w_mext;
    logic                  w_illegal;

    assign w_op   = i_instr[6:0];
    assign w_f3   = i_instr[14:12];
    assign w_f7   = i_instr[31:25];
    assign w_sign = i_instr[31];

    assign w_imm_i = {{52{w_sign}}, i_instr[31:20]};
    assign w_imm_s = {{52{w_sign}}, i_instr[31:25], i_instr[11:7]};
    assign w_imm_b = {{51{w_sign}}, i_instr[31], i_instr[7], i_instr[30:25], i_instr[11:8], 1'b0};
    assign w_imm_u = {{32{w_sign}}, i_instr[31:12], 12'b0};
    assign w_imm_j = {{43{w_sign}}, i_instr[31], i_instr[19:12], i_instr[20], i_instr[30:21], 1'b0};

    always_comb begin
        case (imm_fmt_of(w_op))
            IMM_I:   w_imm = w_imm_i;
            IMM_S:   w_imm = w_imm_s;
            IMM_B:   w_imm = w_imm_b;
            IMM_U:   w_imm = w_imm_u;
            IMM_J:   w_imm = w_imm_j;
            default: w_imm = '0;
        endcase
    end

    always_comb begin
        w_known = 1'b1;
        w_bad   = 1'b0;
        w_wr    = 1'b0;
        w_alt   = 1'b0;
        w_rs1u  = 1'b0;
        w_rs2u  = 1'b0;
        w_mext  = 1'b0;
        case (w_op)
            OP_LUI, OP_AUIPC, OP_JAL: w_wr = 1'b1;
            OP_JALR, OP_LOAD: begin
                w_wr   = 1'b1;
                w_rs1u = 1'b1;
            end
            OP_BRANCH, OP_STORE: begin
                w_rs1u = 1'b1;
                w_rs2u = 1'b1;
            end
            OP_ALUI: begin
                w_wr   = 1'b1;
                w_rs1u = 1'b1;
                // Only the shift-immediates reuse funct7 as an opcode extension.
                if (w_f3 == 3'b001) begin
                    w_bad = (w_f7 != c_F7_BASE);
                end else if (w_f3 == 3'b101) begin
                    w_bad = (w_f7 != c_F7_BASE) && (w_f7 != c_F7_ALT);
                    w_alt = i_instr[30];
                end
            end
            OP_ALU: begin
                w_wr   = 1'b1;
                w_rs1u = 1'b1;
                w_rs2u = 1'b1;
                w_alt  = i_instr[30];
                case (w_f7)
                    c_F7_BASE: w_bad = 1'b0;
                    c_F7_ALT:  w_bad = (w_f3 != 3'b000) && (w_f3 != 3'b101);
                    c_F7_MEXT: begin
                        w_alt = 1'b0;
`ifdef DECODE_MEXT_EN
                        w_mext = 1'b1;
`else
                        w_bad  = 1'b1;
`endif
                    end
                    default:   w_bad = 1'b1;
                endcase
            end
            default: w_known = 1'b0;
        endcase
        w_illegal = (i_instr[1:0] != 2'b11) || !w_known || w_bad;
    end

    always_comb begin
        o_entry          = '0;
        o_entry.pc       = i_pc;
        o_entry.opcode   = w_op;
        o_entry.funct3   = w_f3;
        o_entry.alt      = w_alt;
        o_entry.rs1      = i_instr[19:15];
        o_entry.rs2      = i_instr[24:20];
        o_entry.rd       = i_instr[11:7];
        o_entry.rs1_used = w_rs1u;
        o_entry.rs2_used = w_rs2u;
        o_entry.imm      = w_imm;
        o_entry.we       = w_wr && (i_instr[11:7] != 5'd0) && !w_illegal;
        o_entry.illegal  = w_illegal;
        o_entry.mext     = w_mext;
    end

endmodule

`default_nettype wire

// File: rtl/decode_stage.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : decode_stage
// Brief    : Handshaked RV32I decode stage with a two-entry skid buffer and
//            synchronous flush. DECODE_MEXT_EN enables RV32M decode.
// Revision : 1.0
// ============================================================================
module decode_stage
    import rv_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int REG_AW = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       in_instr,
    input  logic [XLEN-1:0]   in_pc,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [XLEN-1:0]   out_pc,
    output logic [6:0]        out_opcode,
    output logic [2:0]        out_funct3,
    output logic              out_alt,
    output logic [REG_AW-1:0] out_rs1,
    output logic [REG_AW-1:0] out_rs2,
    output logic [REG_AW-1:0] out_rd,
    output logic              out_rs1_used,
    output logic              out_rs2_used,
    output logic [XLEN-1:0]   out_imm,
    output logic              out_we,
    output logic              out_illegal,
    output logic              out_mext
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } buf_state_e;

    buf_state_e            r_state;
    decode_entry_t         r_main;
    decode_entry_t         r_skid;
    decode_entry_t         w_dec;
    logic                  r_out_valid;
    logic                  r_in_ready;
    logic [c_XLEN_MAX-1:0] w_pc_ext;
    logic                  w_accept;
    logic                  w_pop;

    assign w_pc_ext = c_XLEN_MAX'(in_pc);

    decode_logic u_decode (
        .i_instr (in_instr),
        .i_pc    (w_pc_ext),
        .o_entry (w_dec)
    );

    assign w_accept = in_valid && r_in_ready && !flush;
    assign w_pop    = r_out_valid && out_ready;

    // in_ready is precomputed for the next cycle so fetch never sees a
    // combinational path from out_ready.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= ST_EMPTY;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_main      <= '0;
            r_skid      <= '0;
        end else if (flush) begin
            r_state     <= ST_EMPTY;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
        end else begin
            case (r_state)
                ST_EMPTY: begin
                    if (w_accept) begin
                        r_main      <= w_dec;
                        r_out_valid <= 1'b1;
                        r_state     <= ST_ONE;
                    end
                end
                ST_ONE: begin
                    if (w_pop && w_accept) begin
                        r_main <= w_dec;
                    end else if (w_pop) begin
                        r_out_valid <= 1'b0;
                        r_state     <= ST_EMPTY;
                    end else if (w_accept) begin
                        r_skid     <= w_dec;
                        r_in_ready <= 1'b0;
                        r_state    <= ST_TWO;
                    end
                end
                ST_TWO: begin
                    if (w_pop) begin
                        r_main     <= r_skid;
                        r_in_ready <= 1'b1;
                        r_state    <= ST_ONE;
                    end
                end
                default: begin
                    r_state     <= ST_EMPTY;
                    r_out_valid <= 1'b0;
                    r_in_ready  <= 1'b1;
                end
            endcase
        end
    end

    assign in_ready     = r_in_ready;
    assign out_valid    = r_out_valid;
    assign out_pc       = r_main.pc[XLEN-1:0];
    assign out_opcode   = r_main.opcode;
    assign out_funct3   = r_main.funct3;
    assign out_alt      = r_main.alt;
    assign out_rs1      = REG_AW'(r_main.rs1);
    assign out_rs2      = REG_AW'(r_main.rs2);
    assign out_rd       = REG_AW'(r_main.rd);
    assign out_rs1_used = r_main.rs1_used;
    assign out_rs2_used = r_main.rs2_used;
    assign out_imm      = r_main.imm[XLEN-1:0];
    assign out_we       = r_main.we;
    assign out_illegal  = r_main.illegal;
    assign out_mext     = r_main.mext;

    // Upper halves of the wide entry fields are dead on a 32-bit datapath.
    if (XLEN < c_XLEN_MAX) begin : g_narrow_xlen
        logic w_unused_hi;
        assign w_unused_hi = ^{r_main.pc[c_XLEN_MAX-1:XLEN], r_main.imm[c_XLEN_MAX-1:XLEN]};
    end

endmodule

`default_nettype wire

// File: tb/tb_decode_stage.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_decode_stage
// Brief    : Self-checking bench for decode_stage: FIFO scoreboard of decoded
//            entries plus directed literal checks.
// Revision : 1.0
// ============================================================================
module tb_decode_stage;

    localparam int XLEN   = 32;
    localparam int REG_AW = 5;
`ifdef DECODE_MEXT_EN
    localparam bit MEXT = 1'b1;
`else
    localparam bit MEXT = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              flush = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [31:0]       in_instr = '0;
    logic [XLEN-1:0]   in_pc = '0;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [XLEN-1:0]   out_pc;
    logic [6:0]        out_opcode;
    logic [2:0]        out_funct3;
    logic              out_alt;
    logic [REG_AW-1:0] out_rs1;
    logic [REG_AW-1:0] out_rs2;
    logic [REG_AW-1:0] out_rd;
    logic              out_rs1_used;
    logic              out_rs2_used;
    logic [XLEN-1:0]   out_imm;
    logic              out_we;
    logic              out_illegal;
    logic              out_mext;

    decode_stage #(.XLEN(XLEN), .REG_AW(REG_AW)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .flush        (flush),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_instr     (in_instr),
        .in_pc        (in_pc),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_pc       (out_pc),
        .out_opcode   (out_opcode),
        .out_funct3   (out_funct3),
        .out_alt      (out_alt),
        .out_rs1      (out_rs1),
        .out_rs2      (out_rs2),
        .out_rd       (out_rd),
        .out_rs1_used (out_rs1_used),
        .out_rs2_used (out_rs2_used),
        .out_imm      (out_imm),
        .out_we       (out_we),
        .out_illegal  (out_illegal),
        .out_mext     (out_mext)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] pc;
        logic [6:0]  op;
        logic [2:0]  f3;
        logic        alt;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic        rs1u;
        logic        rs2u;
        logic [31:0] imm;
        logic        we;
        logic        ill;
        logic        mext;
    } exp_t;

    int   n_cmp = 0;
    int   n_err = 0;
    int   n_pops = 0;
    bit   mon_en = 1'b0;
    exp_t q[$];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference decode written from the instruction-set rules, using signed
    // arithmetic for immediates.
    function automatic exp_t model(input logic [31:0] w, input logic [31:0] pc);
        exp_t e;
        int   imm;
        bit   writes;
        bit   ok;
        logic [6:0] op;
        logic [2:0] f3;
        logic [6:0] f7;
        op = w[6:0];
        f3 = w[14:12];
        f7 = w[31:25];
        e = '0;
        e.pc = pc; e.op = op; e.f3 = f3;
        e.rs1 = w[19:15]; e.rs2 = w[24:20]; e.rd = w[11:7];
        imm = 0; writes = 0; ok = 1;
        case (op)
            7'h37, 7'h17: begin imm = int'(w & 32'hFFFFF000); writes = 1; end
            7'h6F: begin imm = $signed({w[31], w[19:12], w[20], w[30:21], 1'b0}); writes = 1; end
            7'h67, 7'h03: begin imm = $signed(w[31:20]); writes = 1; e.rs1u = 1; end
            7'h63: begin imm = $signed({w[31], w[7], w[30:25], w[11:8], 1'b0}); e.rs1u = 1; e.rs2u = 1; end
            7'h23: begin imm = $signed({w[31:25], w[11:7]}); e.rs1u = 1; e.rs2u = 1; end
            7'h13: begin
                imm = $signed(w[31:20]); writes = 1; e.rs1u = 1;
                if (f3 == 3'd1) ok = (f7 == 7'h00);
                if (f3 == 3'd5) begin ok = (f7 == 7'h00 || f7 == 7'h20); e.alt = w[30]; end
            end
            7'h33: begin
                writes = 1; e.rs1u = 1; e.rs2u = 1; e.alt = w[30];
                if (f7 == 7'h01 && MEXT) begin e.mext = 1; e.alt = 0; end
                else ok = (f7 == 7'h00) || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5));
            end
            default: ok = 0;
        endcase
        if (w[1:0] != 2'b11) ok = 0;
        e.imm = imm;
        e.ill = !ok;
        e.we  = writes && (w[11:7] != 0) && ok;
        return e;
    endfunction

    exp_t act;
    assign act = {out_pc, out_opcode, out_funct3, out_alt, out_rs1, out_rs2, out_rd,
                  out_rs1_used, out_rs2_used, out_imm, out_we, out_illegal, out_mext};

    // Compare the current outputs, then apply the handshake the coming edge will see.
    always @(negedge clk) begin
        if (mon_en) begin
            chk("out_valid", out_valid, q.size() > 0);
            chk("in_ready", in_ready, q.size() < 2);
            if (q.size() > 0 && out_valid) chk("entry", act, q[0]);
            if (!rst_n || flush) begin
                q.delete();
            end else begin
                if (out_valid && out_ready && q.size() > 0) begin
                    void'(q.pop_front());
                    n_pops++;
                end
                if (in_valid && in_ready) q.push_back(model(in_instr, in_pc));
            end
        end
    end

    task automatic send(input logic [31:0] instr, input logic [31:0] pc);
        bit done;
        in_valid = 1'b1;
        in_instr = instr;
        in_pc    = pc;
        done     = 1'b0;
        for (int i = 0; i < 20 && !done; i++) begin
            @(negedge clk);
            done = in_ready;
            @(posedge clk);
            #1;
        end
        if (!done) chk("send_timeout", 0, 1);
        in_valid = 1'b0;
    endtask

    initial begin
        int pops0;
        // Pin the reference model against hand-decoded words.
        chk("model_addi_imm", model(32'hFFF00093, 0).imm, 32'hFFFFFFFF);
        chk("model_srai_imm", model(32'h40315113, 0).imm, 32'h00000403);
        chk("model_beq_imm",  model(32'hFE000EE3, 0).imm, 32'hFFFFFFFC);
        chk("model_lui_imm",  model(32'h123450B7, 0).imm, 32'h12345000);

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_imm", out_imm, 0);
        chk("rst_out_we", out_we, 0);
        @(posedge clk); #1;
        rst_n  = 1'b1;
        mon_en = 1'b1;
        out_ready = 1'b1;

        send(32'hFFF00093, 32'h100);
        @(negedge clk);
        chk("addi_valid", out_valid, 1);
        chk("addi_rd", out_rd, 1);
        chk("addi_imm", out_imm, 32'hFFFFFFFF);
        chk("addi_we", out_we, 1);
        chk("addi_alt", out_alt, 0);
        chk("addi_rs_used", {out_rs1_used, out_rs2_used}, 2'b10);

        send(32'h40315113, 32'h104);
        @(negedge clk);
        chk("srai_alt", out_alt, 1);
        chk("srai_imm", out_imm, 32'h403);
        chk("srai_rs2_used", out_rs2_used, 0);

        send(32'h402081B3, 32'h108);
        @(negedge clk);
        chk("sub_alt", out_alt, 1);
        chk("sub_rs2_used", out_rs2_used, 1);
        chk("sub_rd", out_rd, 3);

        send(32'hFE000EE3, 32'h10C);
        @(negedge clk);
        chk("beq_imm", out_imm, 32'hFFFFFFFC);
        chk("beq_we", out_we, 0);

        send(32'h00000010, 32'h110);
        @(negedge clk);
        chk("lowbits_illegal", out_illegal, 1);
        chk("lowbits_we", out_we, 0);

        send(32'h02208033, 32'h114);
        @(negedge clk);
        chk("mul_mext", out_mext, MEXT);
        chk("mul_illegal", out_illegal, !MEXT);
        chk("mul_we", out_we, 0);

        // Back-pressure: two entries fill the buffer, the third must wait.
        @(posedge clk); #1;
        out_ready = 1'b0;
        pops0 = n_pops;
        send(32'h00100093, 32'h200);
        send(32'h00200113, 32'h204);
        in_valid = 1'b1;
        in_instr = 32'h00300193;
        in_pc    = 32'h208;
        repeat (3) begin
            @(negedge clk);
            chk("full_in_ready", in_ready, 0);
            chk("full_hold_pc", out_pc, 32'h200);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        send(32'h00300193, 32'h208);
        repeat (4) @(negedge clk);
        chk("bp_all_popped", n_pops - pops0, 3);
        chk("bp_drained", out_valid, 0);

        // Flush while full, with a concurrent offer that must be dropped.
        @(posedge clk); #1;
        out_ready = 1'b0;
        send(32'h00400213, 32'h300);
        send(32'h00500293, 32'h304);
        in_valid = 1'b1;
        in_instr = 32'h00600313;
        in_pc    = 32'h308;
        flush    = 1'b1;
        @(posedge clk); #1;
        flush    = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        pops0 = n_pops;
        @(negedge clk);
        chk("flush_out_valid", out_valid, 0);
        chk("flush_in_ready", in_ready, 1);
        repeat (5) @(negedge clk);
        chk("flush_no_pops", n_pops - pops0, 0);

        send(32'h00700393, 32'h400);
        @(negedge clk);
        chk("post_flush_pc", out_pc, 32'h400);
        repeat (3) @(posedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire
